// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multi-cycle data-memory access engine (req/ack handshake, stall, timeout)
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       is_load;
    logic       cmd_valid;

    assign cmd_valid = (mem_read ^ mem_write) && (addr[1:0] == 2'b00);

    // Combinational so the issuing instruction is held from its very first cycle.
    assign stall = ((state == IDLE) && start && cmd_valid) || (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            is_load    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    load_valid <= 1'b0;
                    err        <= 1'b0;
                    if (start) begin
                        if (cmd_valid) begin
                            mem_addr  <= addr;
                            mem_wdata <= wdata;
                            mem_we    <= mem_write;
                            is_load   <= mem_read;
                            mem_req   <= 1'b1;
                            wait_cnt  <= 8'd0;
                            state     <= BUSY;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // Acknowledge is tested first so an ack in the timeout cycle wins.
                    if (mem_ack) begin
                        if (is_load) begin
                            load_data <= mem_rdata;
                        end
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        load_valid <= 1'b1;
                        state      <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        if (is_load) begin
                            load_data <= 32'd0;
                        end
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        err        <= 1'b1;
                        load_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    load_valid <= 1'b0;
                    err        <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks;
    int failures;

    mem_access_unit #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic s, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        start     = s;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        cmd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        step();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_load_valid", {31'd0, load_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        step();

        // zero-wait load
        cmd(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
        #1;
        check("zw_stall_start", {31'd0, stall}, 32'd1);
        step();
        cmd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("zw_mem_req", {31'd0, mem_req}, 32'd1);
        check("zw_mem_addr", mem_addr, 32'h10);
        check("zw_mem_we", {31'd0, mem_we}, 32'd0);
        check("zw_stall_busy", {31'd0, stall}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        check("zw_load_valid", {31'd0, load_valid}, 32'd1);
        check("zw_load_data", load_data, 32'hDEAD_BEEF);
        check("zw_stall_done", {31'd0, stall}, 32'd0);
        check("zw_req_done", {31'd0, mem_req}, 32'd0);
        check("zw_err", {31'd0, err}, 32'd0);
        step();
        check("zw_lv_drop", {31'd0, load_valid}, 32'd0);

        // three-wait store
        cmd(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678);
        step();
        cmd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("st_we_c%0d", i), {31'd0, mem_we}, 32'd1);
            check($sformatf("st_wdata_c%0d", i), mem_wdata, 32'h1234_5678);
            check($sformatf("st_req_c%0d", i), {31'd0, mem_req}, 32'd1);
            if (i == 3) mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        check("st_load_valid", {31'd0, load_valid}, 32'd1);
        check("st_err", {31'd0, err}, 32'd0);
        check("st_load_data", load_data, 32'hDEAD_BEEF);
        check("st_we_done", {31'd0, mem_we}, 32'd0);
        step();

        // timeout on a load
        cmd(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'd0);
        step();
        cmd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 14; i++) step();
        check("to_req_c15", {31'd0, mem_req}, 32'd1);
        check("to_err_c15", {31'd0, err}, 32'd0);
        step();
        check("to_req_drop", {31'd0, mem_req}, 32'd0);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_load_valid", {31'd0, load_valid}, 32'd1);
        check("to_load_data", load_data, 32'd0);
        check("to_stall", {31'd0, stall}, 32'd0);
        step();
        check("to_err_drop", {31'd0, err}, 32'd0);

        // illegal: misaligned load
        cmd(1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'd0);
        #1;
        check("il1_stall", {31'd0, stall}, 32'd0);
        step();
        cmd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("il1_err", {31'd0, err}, 32'd1);
        check("il1_req", {31'd0, mem_req}, 32'd0);
        check("il1_lv", {31'd0, load_valid}, 32'd0);
        step();
        check("il1_err_drop", {31'd0, err}, 32'd0);

        // illegal: read and write together
        cmd(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'd0);
        #1;
        check("il2_stall", {31'd0, stall}, 32'd0);
        step();
        cmd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("il2_err", {31'd0, err}, 32'd1);
        check("il2_req", {31'd0, mem_req}, 32'd0);
        step();

        // start re-pulsed in BUSY, then ack exactly in the timeout cycle
        cmd(1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'd0);
        step();
        cmd(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'hAAAA_5555);
        step();
        cmd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("ig_mem_addr", mem_addr, 32'h80);
        check("ig_mem_we", {31'd0, mem_we}, 32'd0);
        for (int i = 0; i < 13; i++) step();
        check("ig_req_c15", {31'd0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        check("at_err", {31'd0, err}, 32'd0);
        check("at_load_valid", {31'd0, load_valid}, 32'd1);
        check("at_load_data", load_data, 32'hCAFE_F00D);
        cmd(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'd0);
        #1;
        check("done_start_stall", {31'd0, stall}, 32'd0);
        step();
        check("done_start_req", {31'd0, mem_req}, 32'd0);
        cmd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();

        // asynchronous reset mid-BUSY
        cmd(1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'd0);
        step();
        cmd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("mr_req_before", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_req", {31'd0, mem_req}, 32'd0);
        check("mr_stall", {31'd0, stall}, 32'd0);
        check("mr_load_data", load_data, 32'd0);
        check("mr_err", {31'd0, err}, 32'd0);
        check("mr_load_valid", {31'd0, load_valid}, 32'd0);
        step();
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        step();
        mem_ack = 1'b0;
        check("late_ack_req", {31'd0, mem_req}, 32'd0);
        check("late_ack_lv", {31'd0, load_valid}, 32'd0);
        check("late_ack_ld", load_data, 32'd0);
        check("late_ack_err", {31'd0, err}, 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
